iloveyou_flow_gen: RTL and testbench
====================================

# iloveyou_flow_gen

Stream generator driving the `iloveyou` byte-flow checkers: on a start pulse it emits the 8-letter word I-L-O-V-E-Y-O-U one byte per transfer, with per-letter case control, optional idle gaps between letters and `REPEAT` back-to-back words. While idle it can emit random filler letters that can never begin a match. It sits upstream of the checker as the stimulus/transmit end of the same character-flow interface, replacing free-running `$random` letter sources.

## Interface
- `REPEAT`, 1, words sent per accepted start (legal 1..255).
- `SEED`, 8'h5A, filler LFSR reset seed (must be nonzero).

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to send `REPEAT` words.
- `case_mask`  in  8  bit i=1 sends letter i lowercase; bit 0 = first letter; sampled with start.
- `gap`  in  4  idle cycles inserted between consecutive letters; sampled with start.
- `filler_en`  in  1  emit filler letters while idle.
- `out_ready`  in  1  downstream accepts byte.
- `out_flow`  out  8  ASCII byte.
- `out_valid`  out  1  `out_flow` is valid.
- `busy`  out  1  word sequence in progress.
- `done`  out  1  one-cycle pulse after the final letter transfers.

## Operation
- Transfer occurs on a cycle with `out_valid && out_ready`. While `out_valid && !out_ready`, `out_flow` and `out_valid` hold.
- Letters are 49,4C,4F,56,45,59,4F,55 (hex). Lowercase adds 8'h20.
- States:
  - IDLE: `busy`=0.
    - With `filler_en`=1: `out_valid`=1 and `out_flow` is the filler letter.
    - With `filler_en`=0: `out_valid`=0 and `out_flow`=8'h00.
  - SEND: `out_valid`=1 and `out_flow` is letter[idx].
  - GAP: `out_valid`=0 for exactly `gap` cycles, independent of `out_ready`.
- Start acceptance:
  - `start` in IDLE sets `start_pend`. `start` in SEND or GAP is ignored.
  - `start_pend` moves IDLE→SEND (idx=0, word=0) on the first cycle where no filler byte is stalled: `out_valid`=0, or the filler transfers that cycle.
  - A stalled filler byte is never withdrawn.
- Letter sequencing:
  - On a SEND transfer, if this is not the last letter of the last word: go to GAP if `gap`≠0, else stay in SEND. idx advances mod 8 and word increments on idx wrap.
  - The last letter of the last word goes directly to IDLE, with no trailing gap.
- `done`=1 for the single cycle after the final transfer. `busy`=0 in that same cycle.
- Filler generation:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1. It advances only on a filler transfer.
  - Letter = 'A' + (lfsr[4:0] ≥ 26 ? lfsr[4:0]−26 : lfsr[4:0]).
  - If the result is 'I' it is replaced with 'Z'.
  - Filler is always uppercase.
- Reset (synchronous, any state):
  - State goes to IDLE; `start_pend`, idx, word and the gap counter clear; LFSR = `SEED`.
  - Outputs in the reset cycle and the next: `out_valid`=0, `out_flow`=8'h00, `busy`=0, `done`=0.
  - After that, filler resumes if `filler_en`=1.

## Timing
- `start` in cycle N, idle with `filler_en`=0: first letter presented in cycle N+1.
- With `out_ready`=1 and `gap`=0, one word occupies N+1..N+8 and `done` is high at N+9.
- Word duration with `out_ready`=1 is 8+7·`gap` cycles.
- `REPEAT` words take REPEAT·8 + (REPEAT·8−1)·`gap` cycles.
- Changes to `case_mask`, `gap` or `filler_en` during SEND/GAP have no effect on the current sequence.
- `busy` rises the cycle SEND is entered and falls with `done`.

## Structure
- Package `iloveyou_pkg`:
  - letter constants L_I..L_U and array `WORD[0:7]`;
  - `WORD_LEN`=8 and `CASE_OFS`=8'h20;
  - state enum {IDLE, SEND, GAP}.
- Sub-module `letter_lfsr`: LFSR, letter mapping and the 'I' exclusion. Ports: `clk`, `rst`, `adv`, `letter[7:0]`.
- The top level holds the FSM, `start_pend`, idx/word/gap counters and the output mux.

## Test plan
- Reset: hold `rst`=1 for 2 cycles → `out_valid`=0, `out_flow`=00, `busy`=0, `done`=0. Set `start`=1 during reset → no word is sent afterwards.
- Uppercase word: `case_mask`=00, `gap`=0, `out_ready`=1, `filler_en`=0, `start` at N → 49,4C,4F,56,45,59,4F,55 over N+1..N+8; `done` only at N+9.
- Mixed case with gap and repeat:
  - Setup: `case_mask`=8'hAA, `gap`=2, `REPEAT`=2.
  - Letters must be 49,6C,4F,76,45,79,4F,75 twice.
  - Exactly 2 invalid cycles between letters, 46 cycles total, no gap after the last letter.
- Backpressure: `out_ready`=0 for 3 cycles while 4F is presented → 4F held with `out_valid`=1. A second `start` pulse during the word is ignored, so only one word is sent.
- Filler:
  - `filler_en`=1, `out_ready`=1 for 2000 transfers → all bytes in 41..5A, none 49.
  - Raise `start` while a filler byte is stalled (`out_ready`=0) → that filler byte transfers first, then 49 follows on the next cycle.
- Mid-word reset: assert `rst` while 56 is presented → IDLE, `out_flow`=00, `done` never pulses, and the LFSR sequence restarts from `SEED`.

Source files
------------

// File: rtl/iloveyou_flow_gen_pkg.sv
// iloveyou_pkg: letter constants, word table and FSM states for the iloveyou flow generator
package iloveyou_pkg;
  localparam logic [7:0] L_I = 8'h49;
  localparam logic [7:0] L_L = 8'h4C;
  localparam logic [7:0] L_O = 8'h4F;
  localparam logic [7:0] L_V = 8'h56;
  localparam logic [7:0] L_E = 8'h45;
  localparam logic [7:0] L_Y = 8'h59;
  localparam logic [7:0] L_U = 8'h55;
  localparam int WORD_LEN = 8;
  localparam logic [7:0] CASE_OFS = 8'h20;
  localparam logic [7:0] WORD [0:WORD_LEN-1] = '{L_I, L_L, L_O, L_V, L_E, L_Y, L_O, L_U};
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
endpackage

// File: rtl/iloveyou_flow_gen_if.sv
// iloveyou_flow_gen_if: valid/ready character-flow link between generator and checker
interface iloveyou_flow_gen_if;
  logic [7:0] out_flow;
  logic       out_valid;
  logic       out_ready;
  modport master(output out_flow, output out_valid, input out_ready);
  modport slave(input out_flow, input out_valid, output out_ready);
endinterface

// File: rtl/iloveyou_flow_gen_lfsr.sv
// letter_lfsr: 8-bit Fibonacci LFSR mapped to uppercase filler letters that never start a match
module letter_lfsr #(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [7:0] letter
);
  logic [7:0] lfsr;
  logic [4:0] v;
  logic [7:0] ch;
  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else if (adv) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign v = lfsr[4:0] >= 5'd26 ? lfsr[4:0] - 5'd26 : lfsr[4:0];
  assign ch = 8'h41 + {3'b000, v};
  // 'I' would open a match in the checker, so it is folded onto 'Z'
  assign letter = ch == 8'h49 ? 8'h5A : ch;
endmodule

// File: rtl/iloveyou_flow_gen.sv
// iloveyou_flow_gen: emits I-L-O-V-E-Y-O-U words with case control, gaps and repeats, filler while idle
module iloveyou_flow_gen
  import iloveyou_pkg::*;
#(
  parameter int         REPEAT = 1,
  parameter logic [7:0] SEED   = 8'h5A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            case_mask,
  input  logic [3:0]            gap,
  input  logic                  filler_en,
  iloveyou_flow_gen_if.master   link,
  output logic                  busy,
  output logic                  done
);
  state_t     state;
  logic       start_pend, rst_q, stalled, done_q;
  logic       quiet, xfer, go, last, adv;
  logic [2:0] idx;
  logic [7:0] word, cm_q, filler, letter;
  logic [3:0] gcnt, gap_q;
  letter_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .adv(adv), .letter(filler));
  // outputs stay silent in the reset cycle and the one after it
  assign quiet = rst | rst_q;
  assign letter = WORD[idx] + (cm_q[idx] ? CASE_OFS : 8'h00);
  assign link.out_valid = !quiet && (state == SEND || (state == IDLE && (filler_en || stalled)));
  assign link.out_flow = quiet ? 8'h00 : state == SEND ? letter : link.out_valid ? filler : 8'h00;
  assign xfer = link.out_valid && link.out_ready;
  assign adv = state == IDLE && xfer;
  assign go = state == IDLE && (start || start_pend) && (!link.out_valid || link.out_ready);
  assign last = idx == 3'(WORD_LEN - 1) && word == 8'(REPEAT - 1);
  assign busy = !rst && state != IDLE;
  assign done = done_q && !rst;
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state      <= IDLE;
      start_pend <= 1'b0;
      idx        <= '0;
      word       <= '0;
      gcnt       <= '0;
      done_q     <= 1'b0;
      stalled    <= 1'b0;
      cm_q       <= '0;
      gap_q      <= '0;
    end else begin
      done_q  <= state == SEND && xfer && last;
      stalled <= state == IDLE && link.out_valid && !link.out_ready;
      if (state == IDLE && start) begin
        cm_q  <= case_mask;
        gap_q <= gap;
      end
      case (state)
        IDLE: begin
          start_pend <= go ? 1'b0 : start_pend | start;
          if (go) begin
            state <= SEND;
            idx   <= '0;
            word  <= '0;
          end
        end
        SEND: if (xfer) begin
          if (last) begin
            state <= IDLE;
            idx   <= '0;
            word  <= '0;
          end else begin
            idx <= idx + 3'd1;
            if (idx == 3'(WORD_LEN - 1)) word <= word + 8'd1;
            if (gap_q != 4'd0) begin
              state <= GAP;
              gcnt  <= gap_q;
            end
          end
        end
        GAP: begin
          gcnt <= gcnt - 4'd1;
          if (gcnt == 4'd1) state <= SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iloveyou_flow_gen.sv
// tb_iloveyou_flow_gen: scoreboard bench for the iloveyou flow generator
module tb_iloveyou_flow_gen;
  logic       clk = 1'b0;
  logic       rst, start1, start2, filler_en, ready;
  logic [7:0] case_mask;
  logic [3:0] gap;
  logic       busy1, done1, busy2, done2;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] q[$];
  logic [7:0] lfsr_m;
  logic [7:0] tw [0:7] = '{8'h49, 8'h4C, 8'h4F, 8'h56, 8'h45, 8'h59, 8'h4F, 8'h55};
  iloveyou_flow_gen_if if1 ();
  iloveyou_flow_gen_if if2 ();
  assign if1.out_ready = ready;
  assign if2.out_ready = ready;
  iloveyou_flow_gen #(.REPEAT(1), .SEED(8'h5A)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .case_mask(case_mask), .gap(gap),
    .filler_en(filler_en), .link(if1), .busy(busy1), .done(done1));
  iloveyou_flow_gen #(.REPEAT(2), .SEED(8'h5A)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .case_mask(case_mask), .gap(gap),
    .filler_en(filler_en), .link(if2), .busy(busy2), .done(done2));
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fl(input logic [7:0] s);
    int v;
    v = int'(s) % 32;
    if (v >= 26) v -= 26;
    return (v == 8) ? 8'h5A : 8'(65 + v);
  endfunction

  function automatic logic [7:0] step_lfsr(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic test_reset();
    rst = 1; start1 = 1; start2 = 1; filler_en = 1; ready = 1; case_mask = 0; gap = 0;
    nxt();
    for (int c = 0; c < 13; c++) begin
      if (c == 2) begin rst = 0; start1 = 0; start2 = 0; end
      if (c == 3) filler_en = 0;
      @(negedge clk);
      n_cmp++;
      if (if1.out_valid !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
        n_bad++; $display("FAIL reset c=%0d valid=%b busy=%b done=%b exp 0/0/0", c, if1.out_valid, busy1, done1);
      end
      n_cmp++;
      if (if1.out_flow !== 8'h00) begin
        n_bad++; $display("FAIL reset_flow c=%0d got %h exp 00", c, if1.out_flow);
      end
      nxt();
    end
    lfsr_m = 8'h5A;
  endtask

  task automatic test_upper();
    logic [7:0] e;
    case_mask = 8'h00; gap = 0; ready = 1; filler_en = 0;
    for (int i = 0; i < 8; i++) q.push_back(tw[i]);
    for (int c = 0; c <= 10; c++) begin
      start1 = (c == 0);
      @(negedge clk);
      if (if1.out_valid && ready) begin
        n_cmp++;
        e = q.size() ? q.pop_front() : 8'hxx;
        if (if1.out_flow !== e) begin n_bad++; $display("FAIL upper_flow c=%0d got %h exp %h", c, if1.out_flow, e); end
      end
      n_cmp++;
      if (if1.out_valid !== (c >= 1 && c <= 8)) begin n_bad++; $display("FAIL upper_valid c=%0d got %b", c, if1.out_valid); end
      n_cmp++;
      if (done1 !== (c == 9)) begin n_bad++; $display("FAIL upper_done c=%0d got %b exp %b", c, done1, c == 9); end
      n_cmp++;
      if (busy1 !== (c >= 1 && c <= 8)) begin n_bad++; $display("FAIL upper_busy c=%0d got %b", c, busy1); end
      nxt();
    end
    n_cmp++;
    if (q.size() != 0) begin n_bad++; $display("FAIL upper_left got %0d exp 0", q.size()); q.delete(); end
  endtask

  task automatic test_mixed();
    int first = -1, prev = -1, ntx = 0, ndone = 0, dcyc = -1;
    logic [7:0] e;
    case_mask = 8'hAA; gap = 2; ready = 1; filler_en = 0;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 8; i++) q.push_back(tw[i] + (i % 2 ? 8'h20 : 8'h00));
    for (int c = 0; c <= 52; c++) begin
      start2 = (c == 0);
      if (c == 1) begin case_mask = 8'h00; gap = 0; end
      @(negedge clk);
      if (if2.out_valid && ready) begin
        n_cmp++;
        e = q.size() ? q.pop_front() : 8'hxx;
        if (if2.out_flow !== e) begin n_bad++; $display("FAIL mixed_flow c=%0d got %h exp %h", c, if2.out_flow, e); end
        if (prev >= 0) begin
          n_cmp++;
          if (c - prev != 3) begin n_bad++; $display("FAIL mixed_gap c=%0d spacing %0d exp 3", c, c - prev); end
        end
        if (first < 0) first = c;
        prev = c;
        ntx++;
      end
      if (done2 === 1'b1) begin ndone++; if (dcyc < 0) dcyc = c; end
      nxt();
    end
    n_cmp++;
    if (first != 1 || prev - first + 1 != 46) begin n_bad++; $display("FAIL mixed_span first=%0d span=%0d exp 1/46", first, prev - first + 1); end
    n_cmp++;
    if (ntx != 16) begin n_bad++; $display("FAIL mixed_count got %0d exp 16", ntx); end
    n_cmp++;
    if (ndone != 1 || dcyc != 47) begin n_bad++; $display("FAIL mixed_done count=%0d cyc=%0d exp 1/47", ndone, dcyc); end
    q.delete();
  endtask

  task automatic test_backpressure();
    int ntx = 0, ndone = 0, dcyc = -1;
    logic [7:0] e;
    case_mask = 8'h00; gap = 0; filler_en = 0;
    for (int i = 0; i < 8; i++) q.push_back(tw[i]);
    for (int c = 0; c <= 25; c++) begin
      start1 = (c == 0 || c == 4);
      ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        n_cmp++;
        if (if1.out_valid !== 1'b1 || if1.out_flow !== 8'h4F) begin
          n_bad++; $display("FAIL bp_hold c=%0d valid=%b flow=%h exp 1/4f", c, if1.out_valid, if1.out_flow);
        end
      end
      if (if1.out_valid && ready) begin
        n_cmp++;
        e = q.size() ? q.pop_front() : 8'hxx;
        if (if1.out_flow !== e) begin n_bad++; $display("FAIL bp_flow c=%0d got %h exp %h", c, if1.out_flow, e); end
        ntx++;
      end
      if (done1 === 1'b1) begin ndone++; if (dcyc < 0) dcyc = c; end
      nxt();
    end
    start1 = 0; ready = 1;
    n_cmp++;
    if (ntx != 8) begin n_bad++; $display("FAIL bp_count got %0d exp 8", ntx); end
    n_cmp++;
    if (ndone != 1 || dcyc != 12) begin n_bad++; $display("FAIL bp_done count=%0d cyc=%0d exp 1/12", ndone, dcyc); end
    q.delete();
  endtask

  task automatic test_filler();
    filler_en = 1; ready = 1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      n_cmp++;
      if (if1.out_valid !== 1'b1 || if1.out_flow !== fl(lfsr_m)) begin
        n_bad++; $display("FAIL filler_seq c=%0d valid=%b flow=%h exp 1/%h", c, if1.out_valid, if1.out_flow, fl(lfsr_m));
      end
      n_cmp++;
      if (if1.out_flow < 8'h41 || if1.out_flow > 8'h5A || if1.out_flow == 8'h49) begin
        n_bad++; $display("FAIL filler_range c=%0d got %h exp 41..5a not 49", c, if1.out_flow);
      end
      lfsr_m = step_lfsr(lfsr_m);
      nxt();
    end
  endtask

  task automatic test_filler_stall();
    logic [7:0] e;
    case_mask = 8'h00; gap = 0; filler_en = 1;
    for (int i = 0; i < 8; i++) q.push_back(tw[i]);
    for (int c = 0; c <= 13; c++) begin
      start1 = (c == 0);
      ready = (c >= 3);
      if (c == 13) filler_en = 0;
      @(negedge clk);
      if (c <= 3 || c == 12) begin
        n_cmp++;
        if (if1.out_valid !== 1'b1 || if1.out_flow !== fl(lfsr_m)) begin
          n_bad++; $display("FAIL stall_filler c=%0d valid=%b flow=%h exp 1/%h", c, if1.out_valid, if1.out_flow, fl(lfsr_m));
        end
        if (c == 3 || c == 12) lfsr_m = step_lfsr(lfsr_m);
      end else if (c <= 11) begin
        n_cmp++;
        e = q.size() ? q.pop_front() : 8'hxx;
        if (if1.out_valid !== 1'b1 || if1.out_flow !== e) begin
          n_bad++; $display("FAIL stall_word c=%0d valid=%b flow=%h exp 1/%h", c, if1.out_valid, if1.out_flow, e);
        end
      end else begin
        n_cmp++;
        if (if1.out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_off c=%0d valid=%b exp 0", c, if1.out_valid); end
      end
      n_cmp++;
      if (busy1 !== (c >= 4 && c <= 11)) begin n_bad++; $display("FAIL stall_busy c=%0d got %b", c, busy1); end
      n_cmp++;
      if (done1 !== (c == 12)) begin n_bad++; $display("FAIL stall_done c=%0d got %b exp %b", c, done1, c == 12); end
      nxt();
    end
    q.delete();
  endtask

  task automatic test_midreset();
    logic [7:0] e;
    case_mask = 8'h00; gap = 0; filler_en = 0;
    for (int i = 0; i < 3; i++) q.push_back(tw[i]);
    for (int c = 0; c <= 27; c++) begin
      start1 = (c == 0);
      ready = (c != 4);
      rst = (c == 5);
      if (c == 6) begin filler_en = 1; lfsr_m = 8'h5A; end
      if (c == 27) filler_en = 0;
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        n_cmp++;
        e = q.size() ? q.pop_front() : 8'hxx;
        if (if1.out_flow !== e) begin n_bad++; $display("FAIL mid_flow c=%0d got %h exp %h", c, if1.out_flow, e); end
      end else if (c == 4) begin
        n_cmp++;
        if (if1.out_valid !== 1'b1 || if1.out_flow !== 8'h56) begin
          n_bad++; $display("FAIL mid_pre c=%0d valid=%b flow=%h exp 1/56", c, if1.out_valid, if1.out_flow);
        end
      end else if (c == 5 || c == 6) begin
        n_cmp++;
        if (if1.out_valid !== 1'b0 || if1.out_flow !== 8'h00 || busy1 !== 1'b0) begin
          n_bad++; $display("FAIL mid_rst c=%0d valid=%b flow=%h busy=%b exp 0/00/0", c, if1.out_valid, if1.out_flow, busy1);
        end
      end else if (c >= 7 && c <= 26) begin
        n_cmp++;
        if (if1.out_valid !== 1'b1 || if1.out_flow !== fl(lfsr_m)) begin
          n_bad++; $display("FAIL mid_seed c=%0d valid=%b flow=%h exp 1/%h", c, if1.out_valid, if1.out_flow, fl(lfsr_m));
        end
        lfsr_m = step_lfsr(lfsr_m);
      end
      n_cmp++;
      if (done1 !== 1'b0) begin n_bad++; $display("FAIL mid_done c=%0d got %b exp 0", c, done1); end
      nxt();
    end
    q.delete();
  endtask

  initial begin
    test_reset();
    test_upper();
    test_mixed();
    test_backpressure();
    test_filler();
    test_filler_stall();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
